mul_dot_seq: RTL

- Upstream sequencer for mul_pipeline_32bit.
- Accepts a stream of operand pairs over valid/ready, with `in_last` marking the end of a vector.
- Issues each pair to the multiplier using its one-cycle `req` / `ack` handshake, and accumulates the products.
- Presents the dot-product sum, element count and status flags on a valid/ready result port.

---
 rtl/mul_dot_seq_pkg.sv | 16 +
 rtl/mul_dot_seq_if.sv | 40 ++++
 rtl/mul_dot_seq_acc.sv | 63 ++++++
 rtl/mul_dot_seq.sv | 110 +++++++++++
 4 files changed

// File: rtl/mul_dot_seq_pkg.sv
// Shared types and default sizes for the dot-product sequencer.
package mul_seq_pkg;

  localparam int WIDTH_DEF   = 32;
  localparam int ACC_W_DEF   = 48;
  localparam int CNT_W_DEF   = 16;
  localparam int TIMEOUT_DEF = 80;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    OUT   = 2'd3
  } mul_seq_state_t;

endpackage

// File: rtl/mul_dot_seq_if.sv
// Operand stream, multiplier handshake and result port of the dot-product sequencer.
interface mul_dot_seq_if
  import mul_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_last;

  logic             mul_req;
  logic [WIDTH-1:0] mul_a;
  logic [WIDTH-1:0] mul_b;
  logic             mul_ack;
  logic [WIDTH-1:0] mul_out;

  logic             res_valid;
  logic             res_ready;
  logic [ACC_W-1:0] res_sum;
  logic [CNT_W-1:0] res_count;
  logic             res_ovf;
  logic             res_err;

  // master: the environment (producer, multiplier, consumer); slave: the sequencer
  modport master (
    output in_valid, in_a, in_b, in_last, mul_ack, mul_out, res_ready,
    input  in_ready, mul_req, mul_a, mul_b, res_valid, res_sum, res_count, res_ovf, res_err
  );

  modport slave (
    input  in_valid, in_a, in_b, in_last, mul_ack, mul_out, res_ready,
    output in_ready, mul_req, mul_a, mul_b, res_valid, res_sum, res_count, res_ovf, res_err
  );

endinterface

// File: rtl/mul_dot_seq_acc.sv
// Dot-product accumulator: modulo sum with sticky carry flag, saturating count, sticky error.
module mul_dot_acc #(
  parameter int WIDTH = 32,
  parameter int ACC_W = 48,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             add_i,
  input  logic             err_set_i,
  input  logic [WIDTH-1:0] addend_i,
  output logic [ACC_W-1:0] sum_o,
  output logic [CNT_W-1:0] count_o,
  output logic             ovf_o,
  output logic             err_o
);

  logic [ACC_W-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;
  logic [ACC_W:0]   sum_ext;

  always_comb begin
    sum_ext = {1'b0, sum_q} + (ACC_W+1)'(addend_i);
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    if (clr_i) begin
      sum_d = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
      err_d = 1'b0;
    end else if (add_i) begin
      sum_d = sum_ext[ACC_W-1:0];
      ovf_d = ovf_q | sum_ext[ACC_W];
      if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
      err_d = err_q | err_set_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      sum_q <= sum_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      err_q <= err_d;
    end
  end

  assign sum_o   = sum_q;
  assign count_o = cnt_q;
  assign ovf_o   = ovf_q;
  assign err_o   = err_q;

endmodule

// File: rtl/mul_dot_seq.sv
// Dot-product sequencer: issues operand pairs to a req/ack multiplier and accumulates products.
module mul_dot_seq
  import mul_seq_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int ACC_W   = ACC_W_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic         clk,
  input  logic         rst,
  mul_dot_seq_if.slave seq_if
);

  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  mul_seq_state_t   state_q;
  logic             in_ready_q;
  logic             mul_req_q;
  logic [WIDTH-1:0] mul_a_q;
  logic [WIDTH-1:0] mul_b_q;
  logic             last_q;
  logic             res_valid_q;
  logic [TMO_W-1:0] tmo_q;

  logic             ack_w;
  logic             tmo_w;
  logic             clr_w;

  // An ack in the terminal cycle wins over the timeout
  assign ack_w = (state_q == WAIT) && seq_if.mul_ack;
  assign tmo_w = (state_q == WAIT) && !seq_if.mul_ack && (tmo_q == TMO_W'(TIMEOUT - 1));
  assign clr_w = (state_q == OUT) && seq_if.res_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      mul_req_q   <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      last_q      <= 1'b0;
      res_valid_q <= 1'b0;
      tmo_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (seq_if.in_valid) begin
            mul_a_q    <= seq_if.in_a;
            mul_b_q    <= seq_if.in_b;
            last_q     <= seq_if.in_last;
            in_ready_q <= 1'b0;
            mul_req_q  <= 1'b1;
            state_q    <= ISSUE;
          end
        end
        ISSUE: begin
          mul_req_q <= 1'b0;
          tmo_q     <= '0;
          state_q   <= WAIT;
        end
        WAIT: begin
          if (ack_w || tmo_w) begin
            if (last_q) begin
              res_valid_q <= 1'b1;
              state_q     <= OUT;
            end else begin
              in_ready_q <= 1'b1;
              state_q    <= IDLE;
            end
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end
        OUT: begin
          if (seq_if.res_ready) begin
            res_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  mul_dot_acc #(
    .WIDTH (WIDTH),
    .ACC_W (ACC_W),
    .CNT_W (CNT_W)
  ) u_acc (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (clr_w),
    .add_i     (ack_w | tmo_w),
    .err_set_i (tmo_w),
    .addend_i  (ack_w ? seq_if.mul_out : '0),
    .sum_o     (seq_if.res_sum),
    .count_o   (seq_if.res_count),
    .ovf_o     (seq_if.res_ovf),
    .err_o     (seq_if.res_err)
  );

  assign seq_if.in_ready  = in_ready_q;
  assign seq_if.mul_req   = mul_req_q;
  assign seq_if.mul_a     = mul_a_q;
  assign seq_if.mul_b     = mul_b_q;
  assign seq_if.res_valid = res_valid_q;

endmodule
